ifetch_ctrl: RTL and testbench

Instruction-fetch controller sitting directly upstream of the program counter register. It drives the PC's next-value input (o_next_pc → i_next_pc) and consumes its registered output (current_pc → i_current_pc). It issues one instruction-memory request per PC over a valid/ready plus response-valid interface, and presents the fetched instruction to decode. It also applies branch/jump redirects from execute, discarding any stale in-flight response.

---
 rtl/ifetch_ctrl.sv | 123 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request per PC, redirect handling, drives the PC's next value.
// Optional misaligned-redirect trap with sticky fault and HALT state: define IFETCH_MISALIGN_TRAP_EN.
module ifetch_ctrl #(
   parameter logic [31:0] PC_INC = 32'd4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_current_pc,
   output logic [31:0] o_next_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic        o_fetch_fault
);

`ifdef IFETCH_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {S_REQ = 3'd0, S_WAIT = 3'd1, S_DROP = 3'd2, S_OUT = 3'd3, S_HALT = 3'd4} state_t;
`else
   typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2, S_OUT = 2'd3} state_t;
`endif
   localparam state_t RESET_STATE = S_REQ;

   state_t      state_q, state_d;
   logic [31:0] inst_q;
   logic        capture;
   logic        advance;
   logic        req;
   logic        valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= RESET_STATE;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) inst_q <= i_imem_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      valid   = 1'b0;
      capture = 1'b0;
      advance = 1'b0;
      case (state_q)
         S_REQ: begin
            req = !i_redirect;
            if (req && i_imem_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            // a redirect racing the response throws the response away
            if (i_imem_rvalid) begin
               capture = !i_redirect;
               state_d = i_redirect ? S_REQ : S_OUT;
            end else if (i_redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (i_imem_rvalid) state_d = S_REQ;
         end
         S_OUT: begin
            valid = !i_redirect;
            if (i_redirect) begin
               state_d = S_REQ;
            end else if (!i_stall) begin
               advance = 1'b1;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (state_q != S_HALT && i_redirect && (i_redirect_pc[1:0] != 2'b00)) state_d = S_HALT;
      if (state_q == S_HALT) state_d = S_HALT;
`endif
   end

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic fault_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) fault_q <= 1'b0;
      else if (state_q != S_HALT && i_redirect && (i_redirect_pc[1:0] != 2'b00)) fault_q <= 1'b1;
   end

   always_comb begin
      if (state_q == S_HALT) o_next_pc = i_current_pc;
      else if (i_redirect)   o_next_pc = i_redirect_pc;
      else if (advance)      o_next_pc = i_current_pc + PC_INC;
      else                   o_next_pc = i_current_pc;
   end

   assign o_fetch_fault = fault_q;
`else
   logic unused_lsb;
   assign unused_lsb = ^i_redirect_pc[1:0];

   always_comb begin
      if (i_redirect)   o_next_pc = {i_redirect_pc[31:2], 2'b00};
      else if (advance) o_next_pc = i_current_pc + PC_INC;
      else              o_next_pc = i_current_pc;
   end

   assign o_fetch_fault = 1'b0;
`endif

   assign o_imem_req   = req;
   assign o_imem_addr  = i_current_pc;
   assign o_inst_valid = valid;
   assign o_inst       = inst_q;
   assign o_inst_pc    = i_current_pc;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed test-plan steps plus a randomized phase against a transaction-level model.
module tb_ifetch_ctrl;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_current_pc;
   logic [31:0] o_next_pc;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ready = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        i_stall = 1'b0;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        o_fetch_fault;

   ifetch_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_current_pc(i_current_pc), .o_next_pc(o_next_pc),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ready(i_imem_ready),
      .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata), .i_redirect(i_redirect),
      .i_redirect_pc(i_redirect_pc), .i_stall(i_stall), .o_inst_valid(o_inst_valid),
      .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_fetch_fault(o_fetch_fault)
   );

   always #5 i_clk = ~i_clk;

   // PC stage register
   always_ff @(posedge i_clk) i_current_pc <= i_rst ? 32'd0 : o_next_pc;

   int n_tests = 0;
   int n_fail  = 0;

   // transaction-level model: request in flight, its response doomed, instruction held for decode
   bit          m_pend, m_stale, m_hold;
   logic [31:0] m_inst;
   logic [31:0] acc_q[$];
   bit          last_valid;
   logic [31:0] last_next;
   int          vcount;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_stale = 0; m_hold = 0; m_inst = '0;
   endtask

   task automatic cyc();
      bit          e_req, e_valid;
      logic [31:0] e_next;
      @(negedge i_clk);
      e_req   = !m_pend && !m_hold && !i_redirect;
      e_valid = m_hold && !i_redirect;
`ifdef IFETCH_MISALIGN_TRAP_EN
      e_next  = i_redirect ? i_redirect_pc :
`else
      e_next  = i_redirect ? {i_redirect_pc[31:2], 2'b00} :
`endif
                (m_hold && !i_stall) ? i_current_pc + 32'd4 : i_current_pc;
      if (!i_rst) begin
         chk("imem_req", 32'(o_imem_req), 32'(e_req));
         chk("inst_valid", 32'(o_inst_valid), 32'(e_valid));
         chk("next_pc", o_next_pc, e_next);
         chk("imem_addr", o_imem_addr, i_current_pc);
         chk("inst_pc", o_inst_pc, i_current_pc);
         chk("fetch_fault", 32'(o_fetch_fault), 32'd0);
         if (m_hold) chk("inst", o_inst, m_inst);
      end
      last_valid = o_inst_valid;
      last_next  = o_next_pc;
      if (o_inst_valid) vcount++;
      if (o_imem_req && i_imem_ready && !i_rst) acc_q.push_back(o_imem_addr);
      @(posedge i_clk);
      if (i_rst) model_reset();
      else if (m_pend) begin
         if (i_imem_rvalid) begin
            if (!m_stale && !i_redirect) begin m_hold = 1; m_inst = i_imem_rdata; end
            m_pend = 0; m_stale = 0;
         end else if (i_redirect) m_stale = 1;
      end else if (m_hold) begin
         if (i_redirect || !i_stall) m_hold = 0;
      end else if (e_req && i_imem_ready) begin
         m_pend = 1; m_stale = 0;
      end
      #1;
   endtask

   // run fetches (memory answers next cycle) until an instruction is held; bounded
   task automatic to_hold();
      for (int k = 0; k < 12 && !m_hold; k++) begin
         i_imem_rvalid = m_pend;
         cyc();
      end
      i_imem_rvalid = 0;
      chk("to_hold_reached", 32'(m_hold), 32'd1);
   endtask

   logic [31:0] saved_pc;

   initial begin
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_inst_valid", 32'(o_inst_valid), 32'd0);
      chk("rst_inst", o_inst, 32'd0);
      chk("rst_fault", 32'(o_fetch_fault), 32'd0);
      chk("rst_req", 32'(o_imem_req), 32'd1);
      chk("rst_addr", o_imem_addr, 32'd0);
      i_rst = 0;

      // sequential fetch: three instructions in nine cycles
      i_imem_ready = 1; i_imem_rdata = 32'h0000_0013;
      acc_q.delete(); vcount = 0;
      repeat (9) begin i_imem_rvalid = m_pend; cyc(); end
      i_imem_rvalid = 0;
      chk("seq_nacc", acc_q.size(), 3);
      chk("seq_vcount", vcount, 3);
      if (acc_q.size() == 3) begin
         chk("seq_addr0", acc_q[0], 32'h0);
         chk("seq_addr1", acc_q[1], 32'h4);
         chk("seq_addr2", acc_q[2], 32'h8);
      end

      // stall in OUT
      i_stall = 1;
      to_hold();
      saved_pc = i_current_pc;
      acc_q.delete();
      repeat (4) cyc();
      chk("stall_valid", 32'(last_valid), 32'd1);
      chk("stall_next", last_next, saved_pc);
      chk("stall_inst", o_inst, 32'h0000_0013);
      chk("stall_noreq", acc_q.size(), 0);
      i_stall = 0;
      cyc();
      chk("stall_adv", last_next, saved_pc + 32'd4);

      // redirect while waiting, late response dropped
      cyc();
      vcount = 0;
      i_redirect = 1; i_redirect_pc = 32'h100;
      cyc();
      i_redirect = 0;
      cyc();
      i_imem_rvalid = 1; i_imem_rdata = 32'hDEAD_BEEF;
      cyc();
      i_imem_rvalid = 0;
      acc_q.delete();
      cyc();
      chk("drop_novalid", vcount, 0);
      chk("drop_inst", 32'(o_inst == 32'hDEAD_BEEF), 32'd0);
      chk("drop_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, 32'h100);

      // redirect coincident with response
      vcount = 0;
      i_redirect = 1; i_redirect_pc = 32'h200; i_imem_rvalid = 1; i_imem_rdata = 32'h1111_1111;
      cyc();
      i_redirect = 0; i_imem_rvalid = 0;
      acc_q.delete();
      cyc();
      chk("race_novalid", vcount, 0);
      chk("race_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, 32'h200);
      i_imem_rvalid = 1; cyc(); i_imem_rvalid = 0;
      cyc();

      // PC wrap
      i_redirect = 1; i_redirect_pc = 32'hFFFF_FFFC;
      cyc();
      i_redirect = 0;
      to_hold();
      chk("wrap_pc", i_current_pc, 32'hFFFF_FFFC);
      cyc();
      chk("wrap_next", last_next, 32'h0);

      // randomized phase
      for (int n = 0; n < 500; n++) begin
         i_rst         = ($urandom_range(0, 99) == 0);
         i_imem_ready  = $urandom_range(0, 1);
         i_imem_rvalid = $urandom_range(0, 1);
         i_imem_rdata  = $urandom;
         i_redirect    = ($urandom_range(0, 7) == 0);
         i_redirect_pc = $urandom & 32'hFFFF_FFFC;
         i_stall       = ($urandom_range(0, 2) == 0);
         cyc();
      end
      i_rst = 0; i_redirect = 0; i_stall = 0; i_imem_rvalid = 0; i_imem_ready = 1;
      cyc();

      // misaligned redirect
      i_redirect = 1; i_redirect_pc = 32'h102;
`ifdef IFETCH_MISALIGN_TRAP_EN
      @(negedge i_clk);
      chk("mis_fwd_next", o_next_pc, 32'h102);
      @(posedge i_clk); #1;
      i_redirect = 0;
      repeat (5) begin
         @(negedge i_clk);
         chk("halt_fault", 32'(o_fetch_fault), 32'd1);
         chk("halt_req", 32'(o_imem_req), 32'd0);
         chk("halt_valid", 32'(o_inst_valid), 32'd0);
         chk("halt_next", o_next_pc, i_current_pc);
         @(posedge i_clk); #1;
      end
      i_rst = 1;
      @(posedge i_clk); #1;
      i_rst = 0;
      @(negedge i_clk);
      chk("halt_clr_fault", 32'(o_fetch_fault), 32'd0);
      chk("halt_clr_req", 32'(o_imem_req), 32'd1);
`else
      cyc();
      i_redirect = 0;
      acc_q.delete();
      for (int k = 0; k < 12 && acc_q.size() == 0; k++) begin
         i_imem_rvalid = m_pend;
         cyc();
      end
      i_imem_rvalid = 0;
      chk("mis_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, 32'h100);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
